ps2_frame_rx: RTL and testbench

Parametrised receiver for PS/2-style serial frames. A frame is a start bit (0), DATA_BITS data bits LSB first, an optional parity bit and a stop bit (1). The line device changes `ps2_dat` after a rising edge of `ps2_clk`; the receiver samples on the falling edge. The block oversamples the line on the system clock, deframes and checks each frame, and buffers received words in a FIFO with a valid/ready read port for the host logic.

---
 rtl/ps2_frame_rx.sv | 173 +++++++++++++++++
 tb/tb_ps2_frame_rx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2-style serial frame receiver: line synchroniser, deframer with
// parity/stop checking, and a valid/ready FIFO toward the host.
module ps2_frame_rx #(
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 1,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 2000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ps2_clk,
   input  logic                 ps2_dat,
   output logic                 rd_valid,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rd_err,
   input  logic                 rd_ready,
   output logic                 overflow,
   input  logic                 clear_ovf,
   output logic                 busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DATA_BITS + 1);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int EW = DATA_BITS + 1;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PAR,
      STOP
   } state_t;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   clk_prev;
   logic                   fe;
   logic                   sample;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync <= '1;
         dat_sync <= '1;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
         clk_prev <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign fe     = clk_prev & ~clk_sync[SYNC_STAGES-1];
   assign sample = dat_sync[SYNC_STAGES-1];

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic [WW-1:0]        wd;
   logic                 timeout;

   // Watchdog fires after TIMEOUT consecutive cycles with no falling edge.
   assign timeout = (state != IDLE) && !fe && (wd == WW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         wd      <= '0;
      end else begin
         if (state == IDLE || fe)
            wd <= '0;
         else
            wd <= wd + WW'(1);
         if (timeout) begin
            state <= IDLE;
         end else if (fe) begin
            unique case (state)
               IDLE: begin
                  if (!sample) begin
                     state <= DATA;
                     cnt   <= '0;
                     shreg <= '0;
                  end
               end
               DATA: begin
                  for (int i = 0; i < DATA_BITS; i++)
                     if (cnt == CW'(i))
                        shreg[i] <= sample;
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(DATA_BITS - 1))
                     state <= (PARITY == 0) ? STOP : PAR;
               end
               PAR: begin
                  par_bit <= sample;
                  state   <= STOP;
               end
               STOP: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign busy = (state != IDLE);

   logic par_x;
   logic par_fail;
   logic err;
   logic push;

   assign par_x = (^shreg) ^ par_bit;

   always_comb begin
      par_fail = 1'b0;
      if (PARITY == 1)
         par_fail = ~par_x;
      else if (PARITY == 2)
         par_fail = par_x;
   end

   assign err  = ~sample | par_fail;
   assign push = fe && (state == STOP);

   logic [EW-1:0] mem [DEPTH];
   logic [AW:0]   wp;
   logic [AW:0]   rp;
   logic          empty;
   logic          full;
   logic          pop;
   logic          wr;
   logic          ovf_set;
   logic [EW-1:0] head;

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) &&
                  (wp[AW-1:0] == rp[AW-1:0]);
   assign pop     = rd_valid & rd_ready;
   assign wr      = push & (~full | pop);
   assign ovf_set = push & full & ~pop;

   always_ff @(posedge clk) begin
      if (wr)
         mem[wp[AW-1:0]] <= {err, shreg};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp       <= '0;
         rp       <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr)
            wp <= wp + (AW+1)'(1);
         if (pop)
            rp <= rp + (AW+1)'(1);
         if (ovf_set)
            overflow <= 1'b1;
         else if (clear_ovf)
            overflow <= 1'b0;
      end
   end

   // Head is gated so an empty FIFO never exposes stale storage.
   assign head     = mem[rp[AW-1:0]];
   assign rd_valid = ~empty;
   assign rd_data  = rd_valid ? head[DATA_BITS-1:0] : '0;
   assign rd_err   = rd_valid & head[DATA_BITS];

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Bench for ps2_frame_rx: three instances (default, 9-bit even parity,
// no parity) driven with PS/2 frames and checked through a scoreboard.
module tb_ps2_frame_rx;

   localparam int SYNC = 2;
   localparam int TMO  = 2000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic pc [3];
   logic pd [3];
   logic rdy [3];
   logic clr [3];

   logic       v0, e0, o0, b0;
   logic [7:0] d0;
   logic       v1, e1, o1, b1;
   logic [8:0] d1;
   logic       v2, e2, o2, b2;
   logic [7:0] d2;

   ps2_frame_rx u0 (
      .clk(clk), .reset(reset),
      .ps2_clk(pc[0]), .ps2_dat(pd[0]),
      .rd_valid(v0), .rd_data(d0), .rd_err(e0),
      .rd_ready(rdy[0]), .overflow(o0),
      .clear_ovf(clr[0]), .busy(b0)
   );

   ps2_frame_rx #(.DATA_BITS(9), .PARITY(2)) u1 (
      .clk(clk), .reset(reset),
      .ps2_clk(pc[1]), .ps2_dat(pd[1]),
      .rd_valid(v1), .rd_data(d1), .rd_err(e1),
      .rd_ready(rdy[1]), .overflow(o1),
      .clear_ovf(clr[1]), .busy(b1)
   );

   ps2_frame_rx #(.PARITY(0)) u2 (
      .clk(clk), .reset(reset),
      .ps2_clk(pc[2]), .ps2_dat(pd[2]),
      .rd_valid(v2), .rd_data(d2), .rd_err(e2),
      .rd_ready(rdy[2]), .overflow(o2),
      .clear_ovf(clr[2]), .busy(b2)
   );

   int checks = 0;
   int errors = 0;

   logic [16:0] q0 [$];
   logic [16:0] q1 [$];
   logic [16:0] q2 [$];

   typedef struct {
      logic [15:0] d;
      logic        par;
      logic        stop;
      logic        err;
   } vec_t;

   vec_t vt [19];

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic expect_push(int u, logic [15:0] d, logic e);
      case (u)
         0: q0.push_back({e, d});
         1: q1.push_back({e, d});
         default: q2.push_back({e, d});
      endcase
   endtask

   function automatic int qsize(int u);
      case (u)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic vld(int u);
      case (u)
         0: return v0;
         1: return v1;
         default: return v2;
      endcase
   endfunction

   task automatic pop_chk(int u, logic [15:0] d, logic e);
      logic [16:0] x;
      bit got;
      got = 0;
      x = '0;
      case (u)
         0: if (q0.size() > 0) begin x = q0.pop_front(); got = 1; end
         1: if (q1.size() > 0) begin x = q1.pop_front(); got = 1; end
         default: if (q2.size() > 0) begin x = q2.pop_front(); got = 1; end
      endcase
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL unexpected_pop_u%0d: got %0h expected none",
                  u, {e, d});
      end else begin
         chk($sformatf("pop_u%0d", u), 32'({e, d}), 32'(x));
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (v0 && rdy[0]) pop_chk(0, 16'(d0), e0);
         if (v1 && rdy[1]) pop_chk(1, 16'(d1), e1);
         if (v2 && rdy[2]) pop_chk(2, 16'(d2), e2);
      end
   end

   // One line bit: 6 clocks high, 6 low; optional one-cycle pop
   // aligned to the cycle in which the falling edge is detected.
   task automatic line_bit(int u, logic b, bit pop);
      pd[u] = b;
      step(3);
      pc[u] = 1'b0;
      if (pop) begin
         step(SYNC);
         rdy[u] = 1'b1;
         step(1);
         rdy[u] = 1'b0;
         step(6 - SYNC - 1);
      end else begin
         step(6);
      end
      pc[u] = 1'b1;
      step(3);
   endtask

   task automatic send(int u, logic [15:0] d, int nbits, bit has_par,
                       logic par, logic stop, bit pop_stop);
      line_bit(u, 1'b0, 0);
      for (int i = 0; i < nbits; i++)
         line_bit(u, d[i], 0);
      if (has_par)
         line_bit(u, par, 0);
      line_bit(u, stop, pop_stop);
   endtask

   task automatic drain(int u);
      rdy[u] = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (qsize(u) == 0) break;
         step(1);
      end
      step(1);
      chk($sformatf("drain_left_u%0d", u), 32'(qsize(u)), 0);
      chk($sformatf("drain_empty_u%0d", u), 32'(vld(u)), 0);
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] ov [5];
      for (int i = 0; i < 3; i++) begin
         pc[i]  = 1'b1;
         pd[i]  = 1'b1;
         rdy[i] = 1'b0;
         clr[i] = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
         b = 8'(i);
         vt[i] = '{16'(b), ~^b, 1'b1, 1'b0};
      end
      vt[16] = '{16'h00A5, 1'b1, 1'b1, 1'b0};
      vt[17] = '{16'h00A5, 1'b0, 1'b1, 1'b1};
      vt[18] = '{16'h003C, 1'b1, 1'b0, 1'b1};
      ov[0] = 8'h11; ov[1] = 8'h22; ov[2] = 8'h33;
      ov[3] = 8'h44; ov[4] = 8'h55;

      step(3);
      chk("rst_valid", 32'(v0), 0);
      chk("rst_data", 32'(d0), 0);
      chk("rst_err", 32'(e0), 0);
      chk("rst_ovf", 32'(o0), 0);
      chk("rst_busy", 32'(b0), 0);
      reset = 1'b0;
      step(3);

      rdy[0] = 1'b1;
      for (int i = 0; i < 19; i++) begin
         expect_push(0, vt[i].d, vt[i].err);
         send(0, vt[i].d, 8, 1, vt[i].par, vt[i].stop, 0);
      end
      chk("table_ovf", 32'(o0), 0);
      drain(0);

      rdy[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) expect_push(0, 16'(ov[i]), 1'b0);
         send(0, 16'(ov[i]), 8, 1, ~^ov[i], 1'b1, 0);
      end
      step(2);
      chk("ovf_set", 32'(o0), 1);
      chk("ovf_full_valid", 32'(v0), 1);
      clr[0] = 1'b1;
      step(1);
      clr[0] = 1'b0;
      chk("ovf_clear", 32'(o0), 0);

      b = 8'h66;
      expect_push(0, 16'(b), 1'b0);
      send(0, 16'(b), 8, 1, ~^b, 1'b1, 1);
      step(2);
      chk("full_pop_ovf", 32'(o0), 0);
      drain(0);

      rdy[0] = 1'b0;
      line_bit(0, 1'b0, 0);
      line_bit(0, 1'b1, 0);
      line_bit(0, 1'b0, 0);
      line_bit(0, 1'b1, 0);
      chk("tmo_busy_mid", 32'(b0), 1);
      step(TMO + 10);
      chk("tmo_busy", 32'(b0), 0);
      chk("tmo_no_entry", 32'(v0), 0);
      rdy[0] = 1'b1;
      expect_push(0, 16'h003C, 1'b0);
      send(0, 16'h003C, 8, 1, 1'b1, 1'b1, 0);
      drain(0);

      rdy[1] = 1'b1;
      expect_push(1, 16'h01FF, 1'b0);
      send(1, 16'h01FF, 9, 1, 1'b1, 1'b1, 0);
      expect_push(1, 16'h01FF, 1'b1);
      send(1, 16'h01FF, 9, 1, 1'b0, 1'b1, 0);
      drain(1);
      chk("u1_ovf", 32'(o1), 0);

      rdy[2] = 1'b1;
      expect_push(2, 16'h00AB, 1'b0);
      send(2, 16'h00AB, 8, 0, 1'b0, 1'b1, 0);
      expect_push(2, 16'h00AB, 1'b1);
      send(2, 16'h00AB, 8, 0, 1'b0, 1'b0, 0);
      drain(2);
      chk("u2_ovf", 32'(o2), 0);

      rdy[0] = 1'b0;
      line_bit(0, 1'b0, 0);
      line_bit(0, 1'b1, 0);
      line_bit(0, 1'b1, 0);
      chk("rstmid_busy", 32'(b0), 1);
      reset = 1'b1;
      step(2);
      chk("rstmid_valid", 32'(v0), 0);
      chk("rstmid_data", 32'(d0), 0);
      chk("rstmid_err", 32'(e0), 0);
      chk("rstmid_ovf", 32'(o0), 0);
      chk("rstmid_busy0", 32'(b0), 0);
      reset = 1'b0;
      step(3);
      chk("rstmid_idle", 32'(b0), 0);
      rdy[0] = 1'b1;
      expect_push(0, 16'h005A, 1'b0);
      send(0, 16'h005A, 8, 1, 1'b1, 1'b1, 0);
      drain(0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
